// File: rtl/icache_responder.sv
// icache_responder: direct-mapped read-only instruction cache with single-miss fill FSM
module icache_responder #(
  parameter int NSETS = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = WORD_W - IW - 2;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, next_state;
  logic [NSETS-1:0] valid;
  logic [TW-1:0] tags [NSETS];
  logic [WORD_W-1:0] data [NSETS];
  logic [WORD_W-1:0] miss_addr;
  logic [IW-1:0] idx, fidx;
  logic [TW-1:0] tag;
  logic fill;
  assign idx = imemaddr[IW+1:2];
  assign tag = imemaddr[WORD_W-1:IW+2];
  assign fidx = miss_addr[IW+1:2];
  always_comb begin
    ihit = imemREN && state == IDLE && valid[idx] && tags[idx] == tag;
    imemload = ihit ? data[idx] : '0;
    iREN = state == FETCH;
    iaddr = iREN ? miss_addr : '0;
    fill = iREN && !iwait;
    next_state = state == IDLE ? (imemREN && !ihit ? FETCH : IDLE) : (iwait ? FETCH : IDLE);
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      valid <= '0;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == FETCH) miss_addr <= imemaddr & ~WORD_W'(3);
      if (fill) valid[fidx] <= 1'b1;
    end
  always_ff @(posedge CLK)
    if (fill) begin
      tags[fidx] <= miss_addr[WORD_W-1:IW+2];
      data[fidx] <= iload;
    end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: randomized and directed checks of icache_responder against a word-address cache model
module tb_icache_responder;
  logic CLK = 1'b0;
  logic nRST, imemREN, iwait, ihit, iREN;
  logic [31:0] imemaddr, iload, imemload, iaddr;
  int total = 0, bad = 0;
  bit run_cmp = 1'b0;
  icache_responder dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );
  always #5 CLK = ~CLK;
  logic m_v [16];
  logic [29:0] m_wa [16];
  logic [31:0] m_d [16];
  logic m_pend;
  logic [31:0] m_pa;
  logic e_hit, e_ren;
  logic [31:0] e_load, e_addr;
  assign e_hit = nRST === 1'b1 && imemREN && m_pend === 1'b0 && m_v[imemaddr[5:2]] === 1'b1 && m_wa[imemaddr[5:2]] == imemaddr[31:2];
  assign e_load = e_hit ? m_d[imemaddr[5:2]] : 32'h0;
  assign e_ren = nRST === 1'b1 && m_pend === 1'b1;
  assign e_addr = e_ren ? m_pa : 32'h0;
  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
      m_pend <= 1'b0;
    end else if (m_pend) begin
      if (!iwait) begin
        m_v[m_pa[5:2]] <= 1'b1;
        m_wa[m_pa[5:2]] <= m_pa[31:2];
        m_d[m_pa[5:2]] <= iload;
        m_pend <= 1'b0;
      end
    end else if (imemREN && !e_hit) begin
      m_pend <= 1'b1;
      m_pa <= {imemaddr[31:2], 2'b00};
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  always @(negedge CLK)
    if (run_cmp) begin
      chk("m_ihit", {31'b0, ihit}, {31'b0, e_hit});
      chk("m_imemload", imemload, e_load);
      chk("m_iREN", {31'b0, iREN}, {31'b0, e_ren});
      chk("m_iaddr", iaddr, e_addr);
    end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic set(input logic r, input logic [31:0] a, input logic w, input logic [31:0] l);
    imemREN = r;
    imemaddr = a;
    iwait = w;
    iload = l;
  endtask
  initial begin
    set(0, 0, 0, 0);
    nRST = 1'b1;
    #2 nRST = 1'b0;
    repeat (2) tick;
    nRST = 1'b1;
    run_cmp = 1'b1;
    @(negedge CLK);
    chk("rst_ihit", {31'b0, ihit}, 0);
    chk("rst_iREN", {31'b0, iREN}, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_imemload", imemload, 0);
    tick;
    set(1, 32'h0, 1, 32'h0);
    @(negedge CLK);
    chk("cold_first_ihit", {31'b0, ihit}, 0);
    chk("cold_first_iREN", {31'b0, iREN}, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        iwait = 1'b0;
        iload = 32'h2001_0005;
      end
      @(negedge CLK);
      chk("cold_iREN", {31'b0, iREN}, 1);
      chk("cold_iaddr", iaddr, 32'h0);
      chk("cold_ihit", {31'b0, ihit}, 0);
      tick;
    end
    @(negedge CLK);
    chk("fill_ihit", {31'b0, ihit}, 1);
    chk("fill_imemload", imemload, 32'h2001_0005);
    chk("fill_iREN", {31'b0, iREN}, 0);
    tick;
    imemaddr = 32'h3;
    @(negedge CLK);
    chk("offset_ihit", {31'b0, ihit}, 1);
    chk("offset_imemload", imemload, 32'h2001_0005);
    tick;
    set(1, 32'h40, 0, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk("conf_miss", {31'b0, ihit}, 0);
    tick;
    @(negedge CLK);
    chk("conf_iREN", {31'b0, iREN}, 1);
    chk("conf_iaddr", iaddr, 32'h40);
    tick;
    @(negedge CLK);
    chk("conf_ihit", {31'b0, ihit}, 1);
    chk("conf_imemload", imemload, 32'hDEAD_BEEF);
    tick;
    imemaddr = 32'h0;
    iload = 32'h2001_0005;
    @(negedge CLK);
    chk("evict_miss", {31'b0, ihit}, 0);
    tick;
    @(negedge CLK);
    chk("evict_iREN", {31'b0, iREN}, 1);
    chk("evict_iaddr", iaddr, 32'h0);
    tick;
    @(negedge CLK);
    chk("refill_imemload", imemload, 32'h2001_0005);
    tick;
    set(1, 32'h10, 1, 32'h1111_1111);
    @(negedge CLK);
    chk("chg_miss", {31'b0, ihit}, 0);
    tick;
    imemaddr = 32'h20;
    @(negedge CLK);
    chk("chg_iaddr_hold", iaddr, 32'h10);
    tick;
    iwait = 1'b0;
    @(negedge CLK);
    chk("chg_iaddr_fill", iaddr, 32'h10);
    tick;
    @(negedge CLK);
    chk("chg_new_miss", {31'b0, ihit}, 0);
    chk("chg_idle_iREN", {31'b0, iREN}, 0);
    iload = 32'h2222_2222;
    tick;
    @(negedge CLK);
    chk("chg_new_iaddr", iaddr, 32'h20);
    tick;
    @(negedge CLK);
    chk("chg_hit20", imemload, 32'h2222_2222);
    tick;
    imemaddr = 32'h10;
    @(negedge CLK);
    chk("chg_hit10", imemload, 32'h1111_1111);
    tick;
    set(1, 32'h80, 1, 32'h0);
    tick;
    #2 nRST = 1'b0;
    #1;
    chk("rstmid_iREN", {31'b0, iREN}, 0);
    chk("rstmid_iaddr", iaddr, 0);
    tick;
    nRST = 1'b1;
    set(1, 32'h0, 0, 32'h3333_3333);
    @(negedge CLK);
    chk("rstmid_cold", {31'b0, ihit}, 0);
    tick;
    @(negedge CLK);
    chk("rstmid_iaddr_refetch", iaddr, 32'h0);
    tick;
    @(negedge CLK);
    chk("rstmid_refill", imemload, 32'h3333_3333);
    tick;
    for (int i = 0; i < 10; i++) begin
      set(0, $urandom, i % 2 == 1, $urandom);
      @(negedge CLK);
      chk("idle_ihit", {31'b0, ihit}, 0);
      chk("idle_iREN", {31'b0, iREN}, 0);
      chk("idle_imemload", imemload, 0);
      tick;
    end
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ts;
      nRST = 1'b1;
      ts = 2'($urandom_range(0, 3));
      set($urandom_range(0, 9) != 0, {ts == 2'd3 ? 26'h3FF_FFFF : 26'(ts), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
          $urandom_range(0, 1) == 1, $urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 nRST = 1'b0;
        #1;
        chk("rnd_rst_iREN", {31'b0, iREN}, 0);
      end
      tick;
    end
    nRST = 1'b1;
    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
